// File: rtl/reg_file_mp.sv
// reg_file_mp -- multi-read-port register file with a sequenced clear engine.
//
// One write port and NUM_RD independent registered read ports (1-cycle
// latency, per-port enable). After reset, or on a CLR_REQ pulse in IDLE, the
// clear engine walks every entry to zero, one per clock. While it runs, BUSY
// is high, writes are dropped and the read ports are forced to zero.
//
// Ports:
//   CLK      sole clock, all state changes on posedge
//   RESET_N  synchronous active-low reset
//   RD_EN    [NUM_RD]         per-port read enable
//   RD_ADDR  [NUM_RD*ADDR_W]  port i address at [i*ADDR_W +: ADDR_W]
//   RD_DATA  [NUM_RD*DATA_W]  port i data at [i*DATA_W +: DATA_W], registered
//   WR_EN    write enable
//   WR_ADDR  [ADDR_W] write address
//   WR_DATA  [DATA_W] write data
//   CLR_REQ  single-cycle clear request, honoured in IDLE only
//   BUSY     high while the clear engine runs
//
// The engine state is held in 'state' (type state_t) so checkers can bind to
// it hierarchically.

module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [NUM_RD-1:0]        RD_EN,
  input  logic [NUM_RD*ADDR_W-1:0] RD_ADDR,
  output logic [NUM_RD*DATA_W-1:0] RD_DATA,
  input  logic                     WR_EN,
  input  logic [ADDR_W-1:0]        WR_ADDR,
  input  logic [DATA_W-1:0]        WR_DATA,
  input  logic                     CLR_REQ,
  output logic                     BUSY
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_ptr;
  logic                busy_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                clearing;
  logic                wr_ok;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  assign clearing = (state == ST_CLEAR);

  // A write survives only in IDLE, when no clear is being requested on the
  // same edge, and when it does not target the hardwired zero register.
  assign wr_ok = (state == ST_IDLE) && WR_EN && !CLR_REQ &&
                 !((ZERO_REG != 0) && (WR_ADDR == '0));

  // Array write port is shared by the clear engine and the user write.
  // Gated by RESET_N so reset never touches the array contents.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = WR_ADDR;
    mem_wdata = WR_DATA;
    if (RESET_N) begin
      if (clearing) begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr;
        mem_wdata = '0;
      end else if (wr_ok) begin
        mem_we    = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Clear engine / control FSM.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          // The last entry is cleared on the same edge that leaves CLEAR, so
          // BUSY spans exactly DEPTH edges. The pointer wrap is never seen.
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_IDX) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (CLR_REQ) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          clr_ptr <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign BUSY = busy_q;

  // Read ports: fully independent, each with its own output register.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_q;
    logic              zero_hit;
    logic              byp_hit;

    assign rd_addr  = RD_ADDR[i*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_REG != 0) && (rd_addr == '0);
    // wr_ok already excludes discarded writes, so a zero-register write can
    // never be forwarded.
    assign byp_hit  = (BYPASS != 0) && wr_ok && (rd_addr == WR_ADDR);

    always_ff @(posedge CLK) begin
      if (!RESET_N) begin
        rd_q <= '0;
      end else if (clearing) begin
        rd_q <= '0;
      end else if (RD_EN[i]) begin
        if (zero_hit) begin
          rd_q <= '0;
        end else if (byp_hit) begin
          rd_q <= WR_DATA;
        end else begin
          rd_q <= mem[rd_addr];
        end
      end
    end

    assign RD_DATA[i*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp -- directed testbench for reg_file_mp.
// Two instances share all inputs: dut uses ZERO_REG=1/BYPASS=1, dut_alt uses
// ZERO_REG=0/BYPASS=0, so both flavours of each behaviour are covered.

module tb_reg_file_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD*DATA_W-1:0] rd_data_alt;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     clr_req;
  logic                     busy;
  logic                     busy_alt;

  reg_file_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
    .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .CLK(clk), .RESET_N(reset_n),
    .RD_EN(rd_en), .RD_ADDR(rd_addr), .RD_DATA(rd_data),
    .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .CLR_REQ(clr_req), .BUSY(busy)
  );

  reg_file_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
    .ZERO_REG(0), .BYPASS(0)
  ) dut_alt (
    .CLK(clk), .RESET_N(reset_n),
    .RD_EN(rd_en), .RD_ADDR(rd_addr), .RD_DATA(rd_data_alt),
    .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .CLR_REQ(clr_req), .BUSY(busy_alt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1ns after the active edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rd_en   = '0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    clr_req = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_en   = 2'b11;
    rd_addr = {a1, a0};
    step();
    rd_en   = 2'b00;
  endtask

  // Counts edges until BUSY drops; bounded. Any write set up beforehand is
  // offered only on the first edge.
  task automatic count_busy(output int n);
    n = 0;
    do begin
      step();
      n++;
      wr_en = 1'b0;
    end while (busy && n < 100);
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 32; a += 2) begin
      do_read(ADDR_W'(a), ADDR_W'(a + 1));
      check_eq($sformatf("%s_a%0d", tag, a), rd_data, 64'h0);
      check_eq($sformatf("%s_alt_a%0d", tag, a), rd_data_alt, 64'h0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int nb;
  logic rd_seen_nonzero;

  initial begin
    drive_idle();
    reset_n = 1'b0;

    // 1. reset sequencing
    repeat (3) step();
    check_eq("rst_busy", {63'h0, busy}, 64'h1);
    check_eq("rst_busy_alt", {63'h0, busy_alt}, 64'h1);
    check_eq("rst_rd_data", rd_data, 64'h0);
    check_eq("rst_rd_data_alt", rd_data_alt, 64'h0);

    reset_n = 1'b1;
    rd_en   = 2'b11;
    rd_addr = {5'd3, 5'd1};
    rd_seen_nonzero = 1'b0;
    nb = 0;
    do begin
      step();
      nb++;
      if (rd_data != 64'h0 || rd_data_alt != 64'h0) rd_seen_nonzero = 1'b1;
    end while (busy && nb < 100);
    rd_en = 2'b00;
    check_eq("rst_busy_edges", 64'(nb), 64'd32);
    check_eq("rst_rd_zero_during_clear", {63'h0, rd_seen_nonzero}, 64'h0);
    check_eq("rst_busy_alt_done", {63'h0, busy_alt}, 64'h0);
    read_all_zero("rst_read");

    // 2. basic write/read and hold
    do_write(5'd5, 32'hDEADBEEF);
    do_read(5'd5, 5'd5);
    check_eq("wr_rd_both", rd_data, 64'hDEADBEEF_DEADBEEF);
    check_eq("wr_rd_both_alt", rd_data_alt, 64'hDEADBEEF_DEADBEEF);
    rd_addr = {5'd0, 5'd1};
    step();
    check_eq("rd_hold", rd_data, 64'hDEADBEEF_DEADBEEF);
    check_eq("rd_hold_alt", rd_data_alt, 64'hDEADBEEF_DEADBEEF);

    // 3. bypass: write 7 and read 7 on port0 same edge; port1 disabled
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'h12345678;
    rd_en   = 2'b01;
    rd_addr = {5'd5, 5'd7};
    step();
    drive_idle();
    check_eq("bypass_on", rd_data, 64'hDEADBEEF_12345678);
    check_eq("bypass_off_alt", rd_data_alt, 64'hDEADBEEF_00000000);
    do_read(5'd7, 5'd7);
    check_eq("after_bypass", rd_data, 64'h12345678_12345678);
    check_eq("after_bypass_alt", rd_data_alt, 64'h12345678_12345678);

    // 4. zero register, including same-edge bypass attempt
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'hFFFFFFFF;
    rd_en   = 2'b11;
    rd_addr = {5'd0, 5'd0};
    step();
    drive_idle();
    check_eq("zero_bypass", rd_data, 64'h0);
    check_eq("zero_bypass_alt", rd_data_alt, 64'h0);
    do_read(5'd0, 5'd7);
    check_eq("zero_read", rd_data, 64'h12345678_00000000);
    check_eq("zero_read_alt", rd_data_alt, 64'h12345678_FFFFFFFF);

    // 5. runtime clear
    for (int a = 1; a < 32; a++) do_write(ADDR_W'(a), DATA_W'(a));
    do_read(5'd1, 5'd31);
    check_eq("fill_read", rd_data, {32'd31, 32'd1});
    check_eq("fill_read_alt", rd_data_alt, {32'd31, 32'd1});

    clr_req = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'hAA;
    rd_en   = 2'b11;
    rd_addr = {5'd31, 5'd3};
    step();
    drive_idle();
    check_eq("clr_req_read", rd_data, {32'd31, 32'd3});
    check_eq("clr_req_read_alt", rd_data_alt, {32'd31, 32'd3});
    check_eq("clr_req_busy", {63'h0, busy}, 64'h1);
    count_busy(nb);
    check_eq("clr_busy_edges", 64'(nb), 64'd32);
    check_eq("clr_rd_forced", rd_data, 64'h0);
    read_all_zero("clr_read");

    // 6. reset in the middle of a clear; write during BUSY is lost
    do_write(5'd9, 32'h55);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (9) step();
    reset_n = 1'b0;
    step();
    check_eq("midclr_rst_busy", {63'h0, busy}, 64'h1);
    reset_n = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd12;
    wr_data = 32'h77;
    count_busy(nb);
    check_eq("midclr_busy_edges", 64'(nb), 64'd32);
    check_eq("midclr_busy_alt", {63'h0, busy_alt}, 64'h0);
    read_all_zero("midclr_read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
